sobel_edge_pipe: RTL and testbench

//  Parametrised 3x3 Sobel edge engine. Sits after the 3x3 line-buffer window generator and

---
 rtl/sobel_pkg.sv | 13 +
 rtl/sobel_edge_pipe_if.sv | 28 ++
 rtl/sobel_edge_counter.sv | 47 ++++
 rtl/sobel_edge_pipe.sv | 154 +++++++++++++++
 tb/tb_sobel_edge_pipe.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/sobel_pkg.sv
// Shared encodings and constants for the Sobel edge pipeline.
package sobel_pkg;

  typedef enum logic [1:0] {
    SOBEL_L1  = 2'd0,
    SOBEL_MAX = 2'd1,
    SOBEL_GX  = 2'd2,
    SOBEL_GY  = 2'd3
  } sobel_mode_e;

  localparam int unsigned LAT = 4;

endpackage

// File: rtl/sobel_edge_pipe_if.sv
// Pixel-in / edge-out bundle between the window generator, the Sobel engine and the binarise stage.
interface sobel_edge_pipe_if #(
  parameter int unsigned DATA_W = 10,
  parameter int unsigned OUT_W  = 10,
  parameter int unsigned CNT_W  = 20
);
  logic                  ien;
  logic                  frame_start;
  logic [1:0]            mode;
  logic                  bin_en;
  logic [DATA_W-1:0]     threshold;
  logic [9*DATA_W-1:0]   win;
  logic                  oen;
  logic [OUT_W-1:0]      target_data;
  logic                  edge_flag;
  logic [CNT_W-1:0]      edge_count;
  logic                  count_valid;

  modport master (
    output ien, frame_start, mode, bin_en, threshold, win,
    input  oen, target_data, edge_flag, edge_count, count_valid
  );

  modport slave (
    input  ien, frame_start, mode, bin_en, threshold, win,
    output oen, target_data, edge_flag, edge_count, count_valid
  );
endinterface

// File: rtl/sobel_edge_counter.sv
// Per-frame edge-pixel counter: latches the running total when a frame-start pixel reaches the output.
module sobel_edge_counter #(
  parameter int unsigned CNT_W = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_i,
  input  logic             edge_i,
  input  logic             frame_i,
  output logic [CNT_W-1:0] count_o,
  output logic             pulse_o
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] run_q, run_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             pulse_q, pulse_d;

  // A frame-start pixel closes the previous frame and seeds the new one with its own edge bit.
  always_comb begin
    run_d   = run_q;
    count_d = count_q;
    pulse_d = 1'b0;
    if (valid_i && frame_i) begin
      count_d = run_q;
      pulse_d = 1'b1;
      run_d   = edge_i ? CNT_W'(1) : '0;
    end else if (valid_i && edge_i && (run_q != CNT_MAX)) begin
      run_d = run_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q   <= '0;
      count_q <= '0;
      pulse_q <= 1'b0;
    end else begin
      run_q   <= run_d;
      count_q <= count_d;
      pulse_q <= pulse_d;
    end
  end

  assign count_o = count_q;
  assign pulse_o = pulse_q;
endmodule

// File: rtl/sobel_edge_pipe.sv
// 4-stage 3x3 Sobel engine: gradient taps, abs difference, magnitude/saturate, threshold.
// Frame configuration is shadowed at frame start and travels with each pixel.
module sobel_edge_pipe
  import sobel_pkg::*;
#(
  parameter int unsigned DATA_W = 10,
  parameter int unsigned OUT_W  = 10,
  parameter int unsigned CNT_W  = 20
) (
  input logic              clk,
  input logic              rst_n,
  sobel_edge_pipe_if.slave bus
);
  localparam int unsigned G_W   = DATA_W + 2;
  localparam int unsigned MAG_W = DATA_W + 3;
  localparam int unsigned SAT_W = (MAG_W > OUT_W) ? MAG_W : OUT_W;
  localparam int unsigned THR_W = (OUT_W > DATA_W) ? OUT_W : DATA_W;
  localparam logic [OUT_W-1:0] OUT_MAX = '1;

  typedef struct packed {
    sobel_mode_e       mode;
    logic              bin_en;
    logic [DATA_W-1:0] thr;
  } cfg_t;

  function automatic logic [G_W-1:0] tap3(input logic [DATA_W-1:0] a,
                                          input logic [DATA_W-1:0] b,
                                          input logic [DATA_W-1:0] c);
    return G_W'(a) + G_W'({b, 1'b0}) + G_W'(c);
  endfunction

  function automatic logic [G_W-1:0] absdiff(input logic [G_W-1:0] a, input logic [G_W-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  logic [DATA_W-1:0] d11, d12, d13, d21, d22, d23, d31, d32, d33;
  logic [DATA_W-1:0] unused_d22;

  assign d11 = bus.win[9*DATA_W-1 -: DATA_W];
  assign d12 = bus.win[8*DATA_W-1 -: DATA_W];
  assign d13 = bus.win[7*DATA_W-1 -: DATA_W];
  assign d21 = bus.win[6*DATA_W-1 -: DATA_W];
  assign d22 = bus.win[5*DATA_W-1 -: DATA_W];
  assign d23 = bus.win[4*DATA_W-1 -: DATA_W];
  assign d31 = bus.win[3*DATA_W-1 -: DATA_W];
  assign d32 = bus.win[2*DATA_W-1 -: DATA_W];
  assign d33 = bus.win[DATA_W-1:0];
  assign unused_d22 = d22;

  cfg_t              shadow_q, cfg_in_c;
  logic              v1_q, v2_q, v3_q, fs1_q, fs2_q, fs3_q;
  logic              fs1_d;
  cfg_t              cfg1_q, cfg2_q;
  logic [G_W-1:0]    gx1_q, gx3_q, gy1_q, gy3_q, gx_q, gy_q;
  logic              bin3_q;
  logic [DATA_W-1:0] thr3_q;
  logic [MAG_W-1:0]  mag_full_c;
  logic [SAT_W-1:0]  mag_ext_c;
  logic [OUT_W-1:0]  mag3_d, mag3_q;
  logic              edge_c;
  logic [OUT_W-1:0]  target_d, target_q;
  logic              oen_q, edge_q;

  // A frame-start pixel uses the freshly sampled config; every other pixel uses the shadow.
  always_comb begin
    fs1_d    = bus.ien & bus.frame_start;
    cfg_in_c = shadow_q;
    if (fs1_d) begin
      cfg_in_c.mode   = sobel_mode_e'(bus.mode);
      cfg_in_c.bin_en = bus.bin_en;
      cfg_in_c.thr    = bus.threshold;
    end
  end

  // Magnitude selection and saturation to the output width.
  always_comb begin
    case (cfg2_q.mode)
      SOBEL_L1:  mag_full_c = MAG_W'(gx_q) + MAG_W'(gy_q);
      SOBEL_MAX: mag_full_c = (gx_q >= gy_q) ? MAG_W'(gx_q) : MAG_W'(gy_q);
      SOBEL_GX:  mag_full_c = MAG_W'(gx_q);
      default:   mag_full_c = MAG_W'(gy_q);
    endcase
    mag_ext_c = SAT_W'(mag_full_c);
    mag3_d    = (mag_ext_c > SAT_W'(OUT_MAX)) ? OUT_MAX : OUT_W'(mag_ext_c);
  end

  always_comb begin
    edge_c   = v3_q && (THR_W'(mag3_q) >= THR_W'(thr3_q));
    target_d = '0;
    if (edge_c) target_d = bin3_q ? OUT_MAX : mag3_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
      v1_q     <= 1'b0;
      fs1_q    <= 1'b0;
      cfg1_q   <= '0;
      gx1_q    <= '0;
      gx3_q    <= '0;
      gy1_q    <= '0;
      gy3_q    <= '0;
      v2_q     <= 1'b0;
      fs2_q    <= 1'b0;
      cfg2_q   <= '0;
      gx_q     <= '0;
      gy_q     <= '0;
      v3_q     <= 1'b0;
      fs3_q    <= 1'b0;
      bin3_q   <= 1'b0;
      thr3_q   <= '0;
      mag3_q   <= '0;
      oen_q    <= 1'b0;
      target_q <= '0;
      edge_q   <= 1'b0;
    end else begin
      shadow_q <= cfg_in_c;
      v1_q     <= bus.ien;
      fs1_q    <= fs1_d;
      cfg1_q   <= cfg_in_c;
      gx1_q    <= tap3(d11, d12, d13);
      gx3_q    <= tap3(d31, d32, d33);
      gy1_q    <= tap3(d11, d21, d31);
      gy3_q    <= tap3(d13, d23, d33);
      v2_q     <= v1_q;
      fs2_q    <= fs1_q;
      cfg2_q   <= cfg1_q;
      gx_q     <= absdiff(gx1_q, gx3_q);
      gy_q     <= absdiff(gy1_q, gy3_q);
      v3_q     <= v2_q;
      fs3_q    <= fs2_q;
      bin3_q   <= cfg2_q.bin_en;
      thr3_q   <= cfg2_q.thr;
      mag3_q   <= mag3_d;
      oen_q    <= v3_q;
      target_q <= target_d;
      edge_q   <= edge_c;
    end
  end

  sobel_edge_counter #(.CNT_W(CNT_W)) u_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid_i (v3_q),
    .edge_i  (edge_c),
    .frame_i (fs3_q),
    .count_o (bus.edge_count),
    .pulse_o (bus.count_valid)
  );

  assign bus.oen         = oen_q;
  assign bus.target_data = target_q;
  assign bus.edge_flag   = edge_q;
endmodule

// File: tb/tb_sobel_edge_pipe.sv
// Table-driven and scoreboard bench for sobel_edge_pipe.
module tb_sobel_edge_pipe;
  import sobel_pkg::*;

  localparam int unsigned DATA_W = 10;
  localparam int unsigned OUT_W  = 10;
  localparam int unsigned CNT_W  = 20;
  localparam int          OMAX   = 1023;
  localparam int          CMAX   = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sobel_edge_pipe_if #(.DATA_W(DATA_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) bus ();

  sobel_edge_pipe #(.DATA_W(DATA_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic oen;
    int   tgt;
    logic edg;
    int   cnt;
    logic cv;
  } exp_t;

  typedef struct {
    int   d[9];
    int   mode;
    int   thr;
    logic bin;
    int   xt;
    logic xe;
  } vec_t;

  exp_t sbq[$];
  vec_t tbl[12];
  int   total = 0;
  int   bad = 0;
  int   sh_mode = 0, sh_thr = 0;
  logic sh_bin = 1'b0;
  int   run_cnt = 0, last_cnt = 0;

  int zero_d[9] = '{default: 0};
  int flat[9]   = '{default: 100};
  int tb_rows[9] = '{0, 0, 0, 0, 0, 0, 1023, 1023, 1023};
  int rcol[9]   = '{0, 0, 30, 0, 0, 30, 0, 0, 30};
  int tl[9]     = '{1023, 1023, 1023, 1023, 0, 0, 1023, 0, 0};
  int top40[9]  = '{40, 40, 40, 0, 0, 0, 0, 0, 0};

  function automatic logic [9*DATA_W-1:0] pack(input int d[9]);
    logic [9*DATA_W-1:0] w;
    w = '0;
    for (int i = 0; i < 9; i++) w[(8-i)*DATA_W +: DATA_W] = DATA_W'(d[i]);
    return w;
  endfunction

  function automatic void model(input int d[9], input int mode, input int thr, input logic bin,
                                output int tgt, output logic edg);
    int gx1, gx3, gy1, gy3, gx, gy, mag;
    gx1 = d[0] + 2*d[1] + d[2];
    gx3 = d[6] + 2*d[7] + d[8];
    gy1 = d[0] + 2*d[3] + d[6];
    gy3 = d[2] + 2*d[5] + d[8];
    gx  = (gx1 > gx3) ? gx1 - gx3 : gx3 - gx1;
    gy  = (gy1 > gy3) ? gy1 - gy3 : gy3 - gy1;
    case (mode)
      0:       mag = gx + gy;
      1:       mag = (gx > gy) ? gx : gy;
      2:       mag = gx;
      default: mag = gy;
    endcase
    if (mag > OMAX) mag = OMAX;
    edg = (mag >= thr);
    tgt = edg ? (bin ? OMAX : mag) : 0;
  endfunction

  function automatic vec_t mk(input int d[9], input int mode, input int thr, input logic bin,
                              input int xt, input logic xe);
    vec_t v;
    v.d = d; v.mode = mode; v.thr = thr; v.bin = bin; v.xt = xt; v.xe = xe;
    return v;
  endfunction

  task automatic check_slot(input exp_t e);
    total++;
    if (bus.oen !== e.oen || bus.target_data !== OUT_W'(e.tgt) || bus.edge_flag !== e.edg ||
        bus.edge_count !== CNT_W'(e.cnt) || bus.count_valid !== e.cv) begin
      bad++;
      $display("FAIL slot@%0t: got oen=%0b tgt=%0d edge=%0b cnt=%0d cv=%0b, want oen=%0b tgt=%0d edge=%0b cnt=%0d cv=%0b",
               $time, bus.oen, bus.target_data, bus.edge_flag, bus.edge_count, bus.count_valid,
               e.oen, e.tgt, e.edg, e.cnt, e.cv);
    end
  endtask

  task automatic check_val(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  // Drive one slot, predict its output, and compare the slot that reaches the output now.
  task automatic drive(input logic v, input logic fs, input int d[9], input int mode, input int thr,
                       input logic bin, input logic use_x, input int xt, input logic xe);
    exp_t e;
    int   t;
    logic eg;
    bus.ien         = v;
    bus.frame_start = fs;
    bus.win         = pack(d);
    bus.mode        = 2'(mode);
    bus.threshold   = DATA_W'(thr);
    bus.bin_en      = bin;
    if (v && fs) begin
      sh_mode = mode; sh_thr = thr; sh_bin = bin;
    end
    if (use_x) begin
      t = xt; eg = xe;
    end else begin
      model(d, sh_mode, sh_thr, sh_bin, t, eg);
    end
    e.oen = v;
    e.tgt = v ? t : 0;
    e.edg = v ? eg : 1'b0;
    e.cv  = 1'b0;
    if (v && fs) begin
      last_cnt = run_cnt;
      e.cv     = 1'b1;
      run_cnt  = eg ? 1 : 0;
    end else if (v && eg && run_cnt < CMAX) begin
      run_cnt++;
    end
    e.cnt = last_cnt;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    if (sbq.size() == int'(LAT)) check_slot(sbq.pop_front());
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, zero_d, 0, 0, 1'b0, 1'b0, 0, 1'b0);
  endtask

  initial begin
    int rd[9];
    tbl[0]  = mk(flat,    0,  20, 1'b0, 0,    1'b0);
    tbl[1]  = mk(tb_rows, 2,  20, 1'b0, 1023, 1'b1);
    tbl[2]  = mk(tb_rows, 3,  20, 1'b0, 0,    1'b0);
    tbl[3]  = mk(rcol,    0,  20, 1'b0, 120,  1'b1);
    tbl[4]  = mk(rcol,    1,  20, 1'b0, 120,  1'b1);
    tbl[5]  = mk(rcol,    0, 121, 1'b0, 0,    1'b0);
    tbl[6]  = mk(rcol,    0, 100, 1'b1, 1023, 1'b1);
    tbl[7]  = mk(flat,    0,   0, 1'b0, 0,    1'b1);
    tbl[8]  = mk(rcol,    3, 120, 1'b0, 120,  1'b1);
    tbl[9]  = mk(tl,      0,  20, 1'b0, 1023, 1'b1);
    tbl[10] = mk(rcol,    2,  20, 1'b0, 0,    1'b0);
    tbl[11] = mk(top40,   1,  20, 1'b0, 160,  1'b1);

    bus.ien = 1'b0; bus.frame_start = 1'b0; bus.mode = '0; bus.bin_en = 1'b0;
    bus.threshold = '0; bus.win = '0;
    repeat (3) @(posedge clk);
    #1;
    check_val("reset_oen", int'(bus.oen), 0);
    check_val("reset_target", int'(bus.target_data), 0);
    check_val("reset_count", int'(bus.edge_count), 0);
    check_val("reset_cv", int'(bus.count_valid), 0);
    rst_n = 1'b1;

    // Single-pixel frames, constant expectations.
    for (int i = 0; i < 12; i++)
      drive(1'b1, 1'b1, tbl[i].d, tbl[i].mode, tbl[i].thr, tbl[i].bin, 1'b1, tbl[i].xt, tbl[i].xe);
    repeat (2) idle();

    // Mid-frame config changes are ignored until the next frame-start pixel.
    drive(1'b1, 1'b1, rcol, 0,  20, 1'b0, 1'b1, 120, 1'b1);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, rcol, 2, 200, 1'b1, 1'b1, 120, 1'b1);
    drive(1'b1, 1'b1, rcol, 0, 200, 1'b0, 1'b1, 0, 1'b0);
    drive(1'b1, 1'b0, rcol, 0,  20, 1'b0, 1'b1, 0, 1'b0);
    idle();

    // 50-pixel frame with 17 edges, then a closing frame-start pixel.
    for (int i = 0; i < 50; i++) begin
      if (i < 17) drive(1'b1, (i == 0), rcol, 0, 20, 1'b0, 1'b1, 120, 1'b1);
      else        drive(1'b1, (i == 0), flat, 0, 20, 1'b0, 1'b1, 0,   1'b0);
    end
    drive(1'b1, 1'b1, flat, 0, 20, 1'b0, 1'b1, 0, 1'b0);
    repeat (3) idle();
    check_val("frame50_cv", int'(bus.count_valid), 1);
    check_val("frame50_count", int'(bus.edge_count), 17);
    idle();
    check_val("frame50_cv_drop", int'(bus.count_valid), 0);

    // Reset with three valid pixels in flight.
    repeat (4) idle();
    drive(1'b1, 1'b1, rcol, 0, 20, 1'b0, 1'b1, 120, 1'b1);
    drive(1'b1, 1'b0, rcol, 0, 20, 1'b0, 1'b1, 120, 1'b1);
    drive(1'b1, 1'b0, rcol, 0, 20, 1'b0, 1'b1, 120, 1'b1);
    rst_n = 1'b0;
    #2;
    check_val("midrst_oen", int'(bus.oen), 0);
    check_val("midrst_count", int'(bus.edge_count), 0);
    sbq.delete();
    sh_mode = 0; sh_thr = 0; sh_bin = 1'b0; run_cnt = 0; last_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) idle();

    // Random traffic against the behavioural model.
    for (int n = 0; n < 120; n++) begin
      logic big;
      big = ($urandom_range(0, 1) == 1);
      for (int k = 0; k < 9; k++) rd[k] = big ? int'($urandom_range(0, 1023)) : int'($urandom_range(0, 40));
      drive(($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0), rd,
            int'($urandom_range(0, 3)), int'($urandom_range(0, 300)), ($urandom_range(0, 1) == 1),
            1'b0, 0, 1'b0);
    end
    repeat (5) idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
